// File: rtl/buffer_pkg.sv
// Shared types for the multi-flow buffer: flow ids, scheduler states and default sizing.
package buffer_pkg;
   localparam int FLOW_ID_W = 3;
   localparam int NUM_FLOWS = 2 ** FLOW_ID_W;
   localparam int PKT_CNT_W = 8;

   typedef logic [FLOW_ID_W-1:0] flow_id_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_OFFER,
      S_BUSY
   } sched_state_e;
endpackage

// File: rtl/rr_pick.sv
// Winner select among eligible flows: rotating priority from a start index, or fixed
// lowest-index priority when FLOW_SCHED_STRICT_PRIO_EN is defined (start is then ignored).
module rr_pick #(
   parameter int NUM_FLOWS = 8,
   parameter int IDX_W     = $clog2(NUM_FLOWS)
) (
   input  logic [NUM_FLOWS-1:0] eligible,
   input  logic [IDX_W-1:0]     start,
   output logic [NUM_FLOWS-1:0] winner_onehot,
   output logic [IDX_W-1:0]     winner_idx,
   output logic                 found
);

`ifdef FLOW_SCHED_STRICT_PRIO_EN
   always_comb begin
      winner_idx = '0;
      found      = 1'b0;
      for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner_idx = IDX_W'(i);
            found      = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] probe;

   // Scan from the far end back toward start so the closest eligible flow is written last.
   always_comb begin
      winner_idx = '0;
      found      = 1'b0;
      probe      = '0;
      for (int k = NUM_FLOWS - 1; k >= 0; k--) begin
         probe = start + IDX_W'(k);
         if (eligible[probe]) begin
            winner_idx = probe;
            found      = 1'b1;
         end
      end
   end
`endif

   assign winner_onehot = found ? (NUM_FLOWS'(1) << winner_idx) : '0;

endmodule

// File: rtl/flow_rr_scheduler.sv
// Packet-level read scheduler: per-flow pending-packet counters, round-robin grant to the read
// engine held until pkt_done. Define FLOW_SCHED_STRICT_PRIO_EN for lowest-index-wins priority.
//
//   state   | meaning
//   S_IDLE  | no grant outstanding; offer the next eligible flow
//   S_OFFER | sel_valid high, sel_flow held until sel_ready
//   S_BUSY  | grant accepted, read engine draining the packet until pkt_done
module flow_rr_scheduler
   import buffer_pkg::*;
#(
   parameter  int FLOWS_W = FLOW_ID_W,
   parameter  int CNT_W   = PKT_CNT_W,
   localparam int N_FLOWS = 2 ** FLOWS_W
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               pkt_commit_valid,
   input  logic [FLOWS_W-1:0] pkt_commit_flow,
   input  logic [N_FLOWS-1:0] flow_enable,
   output logic               sel_valid,
   output logic [FLOWS_W-1:0] sel_flow,
   input  logic               sel_ready,
   input  logic               pkt_done,
   output logic               pending_any,
   output logic               overflow_err,
   output logic               underflow_err
);

   sched_state_e       state;
   sched_state_e       state_nxt;

   logic [CNT_W-1:0]   cnt     [N_FLOWS];
   logic [CNT_W-1:0]   cnt_nxt [N_FLOWS];
   logic [FLOWS_W-1:0] rr_ptr;
   logic [FLOWS_W-1:0] sel_flow_r;
   logic [N_FLOWS-1:0] sel_onehot;

   logic [N_FLOWS-1:0] eligible;
   logic [N_FLOWS-1:0] win_onehot;
   logic [FLOWS_W-1:0] win_idx;
   logic               win_found;

   logic [N_FLOWS-1:0] commit_hit;
   logic [N_FLOWS-1:0] release_hit;
   logic               load_grant;
   logic               accept;
   logic               ovf_hit;
   logic               any_nxt;

   // Arbitration sees registered counts, so a commit becomes eligible one cycle later.
   always_comb begin
      eligible = '0;
      for (int f = 0; f < N_FLOWS; f++) begin
         eligible[f] = (cnt[f] != '0) && flow_enable[f];
      end
   end

   rr_pick #(
      .NUM_FLOWS (N_FLOWS),
      .IDX_W     (FLOWS_W)
   ) u_pick (
      .eligible      (eligible),
      .start         (rr_ptr),
      .winner_onehot (win_onehot),
      .winner_idx    (win_idx),
      .found         (win_found)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      load_grant = 1'b0;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (win_found) begin
               load_grant = 1'b1;
               state_nxt  = S_OFFER;
            end
         end
         S_OFFER: begin
            if (sel_ready) begin
               accept    = 1'b1;
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (pkt_done) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign commit_hit  = pkt_commit_valid ? (N_FLOWS'(1) << pkt_commit_flow) : '0;
   assign release_hit = accept ? sel_onehot : '0;

   // A commit and a release on the same flow cancel, so a full counter does not flag overflow then.
   always_comb begin
      ovf_hit = 1'b0;
      any_nxt = 1'b0;
      for (int f = 0; f < N_FLOWS; f++) begin
         cnt_nxt[f] = cnt[f];
         if (commit_hit[f] && !release_hit[f]) begin
            if (&cnt[f]) begin
               ovf_hit = 1'b1;
            end else begin
               cnt_nxt[f] = cnt[f] + 1'b1;
            end
         end else if (release_hit[f] && !commit_hit[f]) begin
            cnt_nxt[f] = cnt[f] - 1'b1;
         end
         any_nxt = any_nxt | (cnt_nxt[f] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int f = 0; f < N_FLOWS; f++) begin
            cnt[f] <= '0;
         end
         rr_ptr        <= '0;
         sel_flow_r    <= '0;
         sel_onehot    <= '0;
         pending_any   <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         for (int f = 0; f < N_FLOWS; f++) begin
            cnt[f] <= cnt_nxt[f];
         end
         if (load_grant) begin
            sel_flow_r <= win_idx;
            sel_onehot <= win_onehot;
         end
`ifdef FLOW_SCHED_STRICT_PRIO_EN
         rr_ptr <= '0;
`else
         if (accept) begin
            rr_ptr <= sel_flow_r + 1'b1;
         end
`endif
         pending_any <= any_nxt;
         if (ovf_hit) begin
            overflow_err <= 1'b1;
         end
         if (pkt_done && (state != S_BUSY)) begin
            underflow_err <= 1'b1;
         end
      end
   end

   assign sel_valid = (state == S_OFFER);
   assign sel_flow  = sel_flow_r;

endmodule

// File: tb/tb_flow_rr_scheduler.sv
// Bench for flow_rr_scheduler: grant-lifecycle reference model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_flow_rr_scheduler;
   import buffer_pkg::*;

   localparam int FW   = FLOW_ID_W;
   localparam int CW   = PKT_CNT_W;
   localparam int NF   = NUM_FLOWS;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rstn;
   logic          pkt_commit_valid;
   flow_id_t      pkt_commit_flow;
   logic [NF-1:0] flow_enable;
   logic          sel_valid;
   flow_id_t      sel_flow;
   logic          sel_ready;
   logic          pkt_done;
   logic          pending_any;
   logic          overflow_err;
   logic          underflow_err;

   flow_rr_scheduler #(.FLOWS_W(FW), .CNT_W(CW)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .pkt_commit_valid (pkt_commit_valid),
      .pkt_commit_flow  (pkt_commit_flow),
      .flow_enable      (flow_enable),
      .sel_valid        (sel_valid),
      .sel_flow         (sel_flow),
      .sel_ready        (sel_ready),
      .pkt_done         (pkt_done),
      .pending_any      (pending_any),
      .overflow_err     (overflow_err),
      .underflow_err    (underflow_err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // Reference model: pending packets per flow plus where the single outstanding grant is.
   int m_cnt [NF];
   bit m_valid, m_busy, m_pend, m_ovf, m_udf;
   int m_flow, m_rr;
   int glog [$];
   bit mo_acc, mo_idle;
   int mo_win, mo_f;

   function automatic int pick_flow();
      for (int k = 0; k < NF; k++) begin
         int f;
         f = (m_rr + k) % NF;
         if (m_cnt[f] != 0 && flow_enable[f]) return f;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!rstn) begin
         for (int f = 0; f < NF; f++) m_cnt[f] = 0;
         m_valid = 0; m_busy = 0; m_pend = 0; m_ovf = 0; m_udf = 0;
         m_flow = 0; m_rr = 0;
      end else begin
         mo_acc  = m_valid && sel_ready;
         mo_idle = !m_valid && !m_busy;
         mo_win  = pick_flow();
         if (pkt_done) begin
            if (m_busy) m_busy = 0;
            else        m_udf  = 1;
         end
         if (mo_acc) begin
            m_cnt[m_flow]--;
            m_valid = 0;
            m_busy  = 1;
            glog.push_back(m_flow);
`ifdef FLOW_SCHED_STRICT_PRIO_EN
            m_rr = 0;
`else
            m_rr = (m_flow + 1) % NF;
`endif
         end else if (mo_idle && mo_win >= 0) begin
            m_valid = 1;
            m_flow  = mo_win;
         end
         if (pkt_commit_valid) begin
            mo_f = int'(pkt_commit_flow);
            if (m_cnt[mo_f] == CMAX) m_ovf = 1;
            else                     m_cnt[mo_f]++;
         end
         m_pend = 0;
         for (int f = 0; f < NF; f++) if (m_cnt[f] != 0) m_pend = 1;
      end
   end

   task automatic check_model();
      vectors++;
      if (sel_valid !== m_valid) begin
         miscompares++;
         $display("FAIL model_sel_valid @%0t: got %b expected %b", $time, sel_valid, m_valid);
      end
      if (m_valid && (sel_flow !== flow_id_t'(m_flow))) begin
         miscompares++;
         $display("FAIL model_sel_flow @%0t: got %0d expected %0d", $time, sel_flow, m_flow);
      end
      if (pending_any !== m_pend) begin
         miscompares++;
         $display("FAIL model_pending_any @%0t: got %b expected %b", $time, pending_any, m_pend);
      end
      if (overflow_err !== m_ovf) begin
         miscompares++;
         $display("FAIL model_overflow_err @%0t: got %b expected %b", $time, overflow_err, m_ovf);
      end
      if (underflow_err !== m_udf) begin
         miscompares++;
         $display("FAIL model_underflow_err @%0t: got %b expected %b", $time, underflow_err, m_udf);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // Advance one clock; outputs are compared at the falling edge, inputs change just after it.
   task automatic tick();
      @(negedge clk);
      if (chk_en) check_model();
      #1;
   endtask

   task automatic quiet();
      pkt_commit_valid = 1'b0;
      sel_ready        = 1'b0;
      pkt_done         = 1'b0;
   endtask

   task automatic commit(input int f);
      pkt_commit_valid = 1'b1;
      pkt_commit_flow  = flow_id_t'(f);
      tick();
      pkt_commit_valid = 1'b0;
   endtask

   // Read engine: accept every offer, pulse pkt_done dly cycles after each accept.
   task automatic serve(input int n, input int dly);
      int got, cd, budget;
      bit v;
      got = 0; cd = 0; budget = n * (dly + 4) + 50;
      sel_ready = 1'b1;
      while ((got < n || cd > 0) && budget > 0) begin
         v        = sel_valid;
         pkt_done = (cd == 1);
         tick();
         budget--;
         if (cd > 0) cd--;
         if (v) begin
            got++;
            cd = dly;
         end
      end
      quiet();
      if (budget == 0) begin
         miscompares++;
         $display("FAIL serve_timeout: got %0d grants expected %0d", got, n);
      end
   endtask

   int exp_order [6];
   int gbase;

   initial begin
`ifdef FLOW_SCHED_STRICT_PRIO_EN
      exp_order = '{1, 1, 3, 3, 6, 6};
`else
      exp_order = '{1, 3, 6, 1, 3, 6};
`endif
      rstn            = 1'b0;
      pkt_commit_flow = '0;
      flow_enable     = '1;
      quiet();
      repeat (2) tick();
      chk_en = 1'b1;
      tick();
      chk("rst_sel_valid", 32'(sel_valid), 0);
      chk("rst_sel_flow", 32'(sel_flow), 0);
      chk("rst_pending_any", 32'(pending_any), 0);
      chk("rst_overflow_err", 32'(overflow_err), 0);
      chk("rst_underflow_err", 32'(underflow_err), 0);
      rstn = 1'b1;
      tick();

      // single packet on flow 5
      commit(5);
      chk("single_valid_c1", 32'(sel_valid), 0);
      tick();
      chk("single_valid_c2", 32'(sel_valid), 1);
      chk("single_flow", 32'(sel_flow), 5);
      serve(1, 3);
      repeat (4) tick();
      chk("single_no_regrant", 32'(sel_valid), 0);
      chk("single_pending", 32'(pending_any), 0);

      // fairness across flows 1, 3, 6
      foreach (exp_order[i]) commit((i % 3 == 0) ? 1 : (i % 3 == 1) ? 3 : 6);
      gbase = glog.size();
      serve(6, 3);
      chk("fair_count", 32'(glog.size() - gbase), 6);
      for (int i = 0; i < 6; i++) begin
         if (gbase + i < glog.size()) chk($sformatf("fair_order_%0d", i), 32'(glog[gbase + i]), 32'(exp_order[i]));
      end

      // backpressure: offer to flow 2 held while flow 0 fills up
      commit(2);
      tick();
      for (int i = 0; i < 10; i++) begin
         pkt_commit_valid = 1'b1;
         pkt_commit_flow  = flow_id_t'(0);
         tick();
         chk("bp_valid_held", 32'(sel_valid), 1);
         chk("bp_flow_held", 32'(sel_flow), 2);
      end
      pkt_commit_valid = 1'b0;
      gbase = glog.size();
      serve(11, 1);
      if (glog.size() >= gbase + 2) begin
         chk("bp_first_grant", 32'(glog[gbase]), 2);
         chk("bp_second_grant", 32'(glog[gbase + 1]), 0);
      end
      chk("bp_pending_drained", 32'(pending_any), 0);

      // commit and accept on flow 4 in the same cycle
      commit(4);
      tick();
      chk("sim_offer_flow", 32'(sel_flow), 4);
      sel_ready        = 1'b1;
      pkt_commit_valid = 1'b1;
      pkt_commit_flow  = flow_id_t'(4);
      tick();
      quiet();
      chk("sim_count_kept", 32'(pending_any), 1);
      chk("sim_valid_busy", 32'(sel_valid), 0);
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      tick();
      chk("sim_regrant_valid", 32'(sel_valid), 1);
      chk("sim_regrant_flow", 32'(sel_flow), 4);
      serve(1, 2);
      chk("sim_pending_drained", 32'(pending_any), 0);

      // enable mask gates flow 2
      flow_enable = 8'b1111_1011;
      commit(2);
      repeat (3) tick();
      chk("mask_no_grant", 32'(sel_valid), 0);
      chk("mask_pending", 32'(pending_any), 1);
      flow_enable = '1;
      tick();
      chk("mask_grant_valid", 32'(sel_valid), 1);
      chk("mask_grant_flow", 32'(sel_flow), 2);
      serve(1, 2);

      // pkt_done while idle
      chk("udf_before", 32'(underflow_err), 0);
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      chk("udf_set", 32'(underflow_err), 1);
      tick();
      chk("udf_stays_idle", 32'(sel_valid), 0);

      // saturate flow 0 with no reads accepted
      pkt_commit_valid = 1'b1;
      pkt_commit_flow  = flow_id_t'(0);
      repeat (CMAX) tick();
      chk("sat_ovf_at_255", 32'(overflow_err), 0);
      tick();
      pkt_commit_valid = 1'b0;
      chk("sat_ovf_at_256", 32'(overflow_err), 1);
      gbase = glog.size();
      serve(CMAX, 1);
      chk("sat_drain_count", 32'(glog.size() - gbase), 32'(CMAX));
      chk("sat_drained", 32'(pending_any), 0);

      // reset while a packet is in flight
      pkt_commit_valid = 1'b1;
      pkt_commit_flow  = flow_id_t'(3);
      repeat (2) tick();
      pkt_commit_valid = 1'b0;
      tick();
      sel_ready = 1'b1;
      tick();
      sel_ready = 1'b0;
      rstn = 1'b0;
      tick();
      chk("rbusy_valid", 32'(sel_valid), 0);
      chk("rbusy_pending", 32'(pending_any), 0);
      chk("rbusy_ovf", 32'(overflow_err), 0);
      chk("rbusy_udf", 32'(underflow_err), 0);
      rstn = 1'b1;
      repeat (3) tick();
      chk("rbusy_no_grant", 32'(sel_valid), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         pkt_commit_valid = ($urandom_range(0, 1) == 1);
         pkt_commit_flow  = flow_id_t'($urandom_range(0, NF - 1));
         sel_ready        = ($urandom_range(0, 2) != 0);
         pkt_done         = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 39) == 0) flow_enable = NF'($urandom) | NF'($urandom);
         rstn = ($urandom_range(0, 499) != 0);
         tick();
      end
      quiet();
      rstn = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/flow_rr_scheduler.md
Name: flow_rr_scheduler

Overview:
Packet-level read scheduler for the multi-flow buffer. It counts complete packets committed per flow on the write side. It picks the next flow to drain, round-robin among eligible flows, and hands that flow to the read engine. It holds the grant until the read engine reports the packet fully transmitted. It sits between the write-side pointer-commit path and the read/pointer-release engine.

Parameters:
FLOWS_W, 3, flow id width; NUM_FLOWS = 2**FLOWS_W
CNT_W, 8, per-flow pending-packet counter width

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
pkt_commit_valid  in  1  one complete packet (last segment) committed to buffer
pkt_commit_flow  in  FLOWS_W  flow of committed packet
flow_enable  in  NUM_FLOWS  per-flow scheduling enable mask
sel_valid  out  1  grant offered to read engine
sel_flow  out  FLOWS_W  granted flow
sel_ready  in  1  read engine accepts grant
pkt_done  in  1  read engine finished current packet (last beat handshaked)
pending_any  out  1  OR of all per-flow counters non-zero
overflow_err  out  1  sticky: commit arrived on saturated counter
underflow_err  out  1  sticky: pkt_done while not BUSY

Behaviour:
- Reset values: sel_valid=0, sel_flow=0, pending_any=0, overflow_err=0, underflow_err=0.
- Reset clears all counters to 0, the RR pointer to 0 and the state to IDLE. Reset mid-packet abandons the grant with no pkt_done required.
- Counter flow f:
  - +1 on pkt_commit_valid with pkt_commit_flow==f.
  - -1 on grant accept (sel_valid && sel_ready && sel_flow==f).
  - Both in the same cycle: net unchanged.
  - Increment at all-ones: counter holds and overflow_err sets.
  - The decrement never underflows, because a grant is only offered when the counter is >0.
- Eligibility: flow f is eligible when count[f]!=0 and flow_enable[f]. Eligibility uses registered counters, so a commit is visible to arbitration one cycle later.
- RR select: first eligible flow starting at rr_ptr and wrapping at NUM_FLOWS-1 to 0. On accept, rr_ptr is set to sel_flow+1 (mod NUM_FLOWS).
- FSM:
  - IDLE: if any flow is eligible, register sel_flow=winner, sel_valid=1, go to OFFER. Latency is 1 cycle from eligibility to sel_valid.
  - OFFER: sel_valid and sel_flow are held stable until sel_ready. On sel_ready: sel_valid=0, counter decrements, go to BUSY. A flow_enable drop while in OFFER does not withdraw the grant.
  - BUSY: wait for pkt_done, then go to IDLE. The next grant can appear the cycle after IDLE is entered, so the minimum grant-to-grant spacing is accept + pkt_done + 1.
- pkt_done in IDLE or OFFER is ignored and sets underflow_err.
- pending_any is registered and reflects the counters after the current cycle's update.
- Error flags clear only on reset.

Optional Feature:
- Macro: FLOW_SCHED_STRICT_PRIO_EN.
- Defined: strict priority; the lowest eligible flow index always wins, and rr_ptr is unused and held at 0.
- Undefined: round-robin as above.
- Ports and FSM are identical in both builds.

Decomposition:
- Shared package buffer_pkg holds:
  - flow_id_t (logic [FLOWS_W-1:0])
  - sched_state_e enum {S_IDLE, S_OFFER, S_BUSY}
  - NUM_FLOWS constant
- One sub-module, rr_pick: combinational eligible mask plus start pointer in, one-hot/index winner plus found flag out. It is parameterised by NUM_FLOWS and also implements the priority variant under the macro.

Test Plan:
- Single flow: commit flow 5 once, sel_ready=1 → sel_valid at cycle+2 with sel_flow=5. Counter[5] returns to 0. pkt_done → IDLE, no further grant, pending_any=0.
- Fairness: 2 packets each on flows 1, 3 and 6, sel_ready=1, pkt_done 3 cycles after each accept → grant order 1,3,6,1,3,6. Same stimulus with FLOW_SCHED_STRICT_PRIO_EN → 1,1,3,3,6,6.
- Backpressure: hold sel_ready=0 for 10 cycles with flow 2 pending and commits arriving on flow 0 → sel_flow stays 2, sel_valid stays 1, no switch to flow 0.
- Simultaneous events: commit on flow 4 in the same cycle flow 4's grant is accepted with count=1 → count stays 1 and flow 4 is re-granted after pkt_done.
- Saturation and errors:
  - 256 commits on flow 0 (CNT_W=8, no reads) → count=255 and overflow_err=1.
  - pkt_done pulse in IDLE → underflow_err=1, state unchanged.
- Enable mask / reset: flow_enable=8'b1111_1011 with only flow 2 pending → no grant; enabling bit 2 → grant flow 2. Assert rstn=0 while BUSY → next cycle sel_valid=0, all counters 0.
